register_file_scanner: RTL and testbench

REGISTER_FILE_SCANNER -- requirements
Module: register_file_scanner

---
 rtl/register_file_scanner_pkg.sv | 12 +
 rtl/register_file_scanner_min_tracker.sv | 36 +++
 rtl/register_file_scanner.sv | 107 ++++++++++
 tb/tb_register_file_scanner.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/register_file_scanner_pkg.sv
// rtl/register_file_scanner_pkg.sv - shared scanner/register-file constants and FSM encoding
package register_file_scanner_pkg;

   localparam int DEFAULT_WIDTH = 13;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_SELECT  = 3'd1;
   localparam logic [2:0] ST_CAPTURE = 3'd2;
   localparam logic [2:0] ST_EMIT    = 3'd3;
   localparam logic [2:0] ST_FINISH  = 3'd4;

endpackage

// File: rtl/register_file_scanner_min_tracker.sv
// rtl/register_file_scanner_min_tracker.sv - running minimum of non-zero values with index
module min_tracker
   import register_file_scanner_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int IW    = 3
) (
   input  logic             Clock,
   input  logic             CLRN,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] value,
   input  logic [IW-1:0]    index,
   output logic [WIDTH-1:0] best,
   output logic [IW-1:0]    best_index,
   output logic             best_valid
);

   logic take;

   // Strict less-than keeps the earlier (lower) index on ties; zeros never qualify.
   assign take = load && (value != '0) && (!best_valid || (value < best));

   always_ff @(posedge Clock) begin
      if (!CLRN || clear) begin
         best       <= '0;
         best_index <= '0;
         best_valid <= 1'b0;
      end else if (take) begin
         best       <= value;
         best_index <= index;
         best_valid <= 1'b1;
      end
   end

endmodule

// File: rtl/register_file_scanner.sv
// rtl/register_file_scanner.sv - walks register rows, streams each one, reports the minimum non-zero row
module register_file_scanner
   import register_file_scanner_pkg::*;
#(
   parameter int ROWS  = 8,
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                      Clock,
   input  logic                      CLRN,
   input  logic                      Start,
   input  logic [$clog2(ROWS):0]     Count,
   output logic [$clog2(ROWS)-1:0]   RowSel,
   input  logic [WIDTH-1:0]          RowQ,
   output logic [WIDTH-1:0]          OutData,
   output logic [$clog2(ROWS)-1:0]   OutIndex,
   output logic                      OutValid,
   input  logic                      OutReady,
   output logic [WIDTH-1:0]          Best,
   output logic [$clog2(ROWS)-1:0]   BestIndex,
   output logic                      BestValid,
   output logic                      Busy,
   output logic                      Done
);

   localparam int IW = $clog2(ROWS);
   localparam int CW = IW + 1;

   logic [2:0]       state;
   logic [IW-1:0]    index;
   logic [CW-1:0]    limit;
   logic [CW-1:0]    clamp;
   logic             accept;
   logic             last_row;
   logic [WIDTH-1:0] trk_best;
   logic [IW-1:0]    trk_index;
   logic             trk_valid;

   assign clamp    = (Count > CW'(ROWS)) ? CW'(ROWS) : Count;
   assign accept   = (state == ST_IDLE) && Start;
   assign last_row = ({1'b0, index} + CW'(1)) >= limit;

   // Outputs decode from registered state only, so OutReady never reaches OutValid combinationally.
   assign RowSel   = index;
   assign OutValid = (state == ST_EMIT);
   assign Busy     = (state != ST_IDLE);
   assign Done     = (state == ST_FINISH);

   always_ff @(posedge Clock) begin
      if (!CLRN) begin
         state     <= ST_IDLE;
         index     <= '0;
         limit     <= '0;
         OutData   <= '0;
         OutIndex  <= '0;
         Best      <= '0;
         BestIndex <= '0;
         BestValid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (Start) begin
                  limit     <= clamp;
                  index     <= '0;
                  BestValid <= 1'b0;
                  state     <= (clamp == '0) ? ST_FINISH : ST_SELECT;
               end
            end
            ST_SELECT:  state <= ST_CAPTURE;
            ST_CAPTURE: begin
               OutData  <= RowQ;
               OutIndex <= index;
               state    <= ST_EMIT;
            end
            ST_EMIT: begin
               if (OutReady) begin
                  if (last_row) begin
                     state <= ST_FINISH;
                  end else begin
                     index <= index + 1'b1;
                     state <= ST_SELECT;
                  end
               end
            end
            ST_FINISH: begin
               Best      <= trk_best;
               BestIndex <= trk_index;
               BestValid <= trk_valid;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   min_tracker #(.WIDTH(WIDTH), .IW(IW)) u_min (
      .Clock      (Clock),
      .CLRN       (CLRN),
      .clear      (accept),
      .load       (state == ST_CAPTURE),
      .value      (RowQ),
      .index      (index),
      .best       (trk_best),
      .best_index (trk_index),
      .best_valid (trk_valid)
   );

endmodule

// File: tb/tb_register_file_scanner.sv
// tb/tb_register_file_scanner.sv - directed scoreboard bench for register_file_scanner
module tb_register_file_scanner;

   logic        Clock;
   logic        CLRN;
   logic        Start;
   logic [3:0]  Count;
   logic [2:0]  RowSel;
   logic [12:0] RowQ;
   logic [12:0] OutData;
   logic [2:0]  OutIndex;
   logic        OutValid;
   logic        OutReady;
   logic [12:0] Best;
   logic [2:0]  BestIndex;
   logic        BestValid;
   logic        Busy;
   logic        Done;

   logic [12:0] rows [8];
   logic [15:0] sb [$];
   int          total = 0;
   int          bad   = 0;
   int          maxsel = 0;

   register_file_scanner #(.ROWS(8), .WIDTH(13)) dut (
      .Clock(Clock), .CLRN(CLRN), .Start(Start), .Count(Count),
      .RowSel(RowSel), .RowQ(RowQ), .OutData(OutData), .OutIndex(OutIndex),
      .OutValid(OutValid), .OutReady(OutReady), .Best(Best), .BestIndex(BestIndex),
      .BestValid(BestValid), .Busy(Busy), .Done(Done)
   );

   assign RowQ = rows[RowSel];

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   initial begin
      #500000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   // Beats are compared on the negedge before the handshake edge.
   always @(negedge Clock) begin
      if (CLRN) begin
         if (int'(RowSel) > maxsel) maxsel = int'(RowSel);
         if (OutValid && OutReady) begin
            logic [15:0] exp;
            total++;
            if (sb.size() == 0) begin
               bad++;
               $error("FAIL beat_extra observed=%0d:%0h expected=none", OutIndex, OutData);
            end else begin
               exp = sb.pop_front();
               assert ({OutIndex, OutData} === exp[15:0]) else begin
                  bad++;
                  $error("FAIL beat observed=%0d:%0h expected=%0d:%0h",
                         OutIndex, OutData, exp[15:13], exp[12:0]);
               end
            end
         end
      end
   end

   task automatic model(input int lim, output logic [12:0] b, output logic [2:0] bi,
                        output logic bv);
      b = '0; bi = '0; bv = 1'b0;
      for (int i = 0; i < lim; i++) begin
         if (rows[i] != 0 && (!bv || rows[i] < b)) begin
            b = rows[i]; bi = 3'(i); bv = 1'b1;
         end
      end
   endtask

   task automatic start_scan(input int cnt);
      int lim;
      lim = (cnt > 8) ? 8 : cnt;
      for (int i = 0; i < lim; i++) sb.push_back({3'(i), rows[i]});
      Start = 1'b1;
      Count = 4'(cnt);
      step();
      Start = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 1;
      while (!Done && cyc < 300) begin
         step();
         cyc++;
      end
      if (!Done) check("done_timeout", 32'(cyc), 32'hffff);
   endtask

   task automatic finish_checks(input string tag, input int cnt);
      logic [12:0] b;
      logic [2:0]  bi;
      logic        bv;
      model((cnt > 8) ? 8 : cnt, b, bi, bv);
      step();
      check({tag, "_best"}, 32'(Best), 32'(b));
      check({tag, "_best_index"}, 32'(BestIndex), 32'(bi));
      check({tag, "_best_valid"}, 32'(BestValid), 32'(bv));
      check({tag, "_busy_idle"}, 32'(Busy), 32'd0);
      check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rowsel"}, 32'(RowSel), 0);
      check({tag, "_outdata"}, 32'(OutData), 0);
      check({tag, "_outindex"}, 32'(OutIndex), 0);
      check({tag, "_outvalid"}, 32'(OutValid), 0);
      check({tag, "_best"}, 32'(Best), 0);
      check({tag, "_bestindex"}, 32'(BestIndex), 0);
      check({tag, "_bestvalid"}, 32'(BestValid), 0);
      check({tag, "_busy"}, 32'(Busy), 0);
      check({tag, "_done"}, 32'(Done), 0);
   endtask

   initial begin
      int cyc;
      logic [12:0] hold_d;
      logic [2:0]  hold_i;
      logic        stable;
      int          guard;

      CLRN = 1'b0; Start = 1'b0; Count = '0; OutReady = 1'b1;
      for (int i = 0; i < 8; i++) rows[i] = '0;
      step(); step();
      check_reset_outputs("reset");
      CLRN = 1'b1;
      step();

      // Reference scan: ties on 320 keep index 1.
      rows[0] = 500; rows[1] = 320; rows[2] = 0; rows[3] = 320;
      rows[4] = 900; rows[5] = 0;   rows[6] = 0; rows[7] = 0;
      start_scan(8);
      wait_done(cyc);
      check("ref_done_latency", 32'(cyc), 32'd25);
      finish_checks("ref", 8);

      // Empty scan.
      start_scan(0);
      check("cnt0_busy", 32'(Busy), 1);
      check("cnt0_done", 32'(Done), 1);
      step();
      check("cnt0_busy_after", 32'(Busy), 0);
      check("cnt0_done_after", 32'(Done), 0);
      check("cnt0_bestvalid", 32'(BestValid), 0);
      check("cnt0_sb_empty", 32'(sb.size()), 0);

      // Clamped count.
      rows[0] = 7; rows[1] = 3; rows[2] = 9; rows[3] = 3;
      rows[4] = 0; rows[5] = 12; rows[6] = 1; rows[7] = 8191;
      maxsel = 0;
      start_scan(12);
      wait_done(cyc);
      check("clamp_latency", 32'(cyc), 32'd25);
      check("clamp_rowsel_max", 32'(maxsel), 32'd7);
      finish_checks("clamp", 12);

      // Backpressure on beat 2.
      rows[6] = 5; rows[2] = 4;
      start_scan(8);
      guard = 0;
      while (!(RowSel == 3'd2 && !OutValid) && guard < 50) begin step(); guard++; end
      OutReady = 1'b0;
      guard = 0;
      while (!OutValid && guard < 50) begin step(); guard++; end
      hold_d = OutData; hold_i = OutIndex;
      check("stall_index", 32'(hold_i), 32'd2);
      check("stall_data", 32'(hold_d), 32'd4);
      stable = 1'b1;
      repeat (5) begin
         step();
         if (!(OutValid && OutData == hold_d && OutIndex == hold_i)) stable = 1'b0;
      end
      check("stall_stable", 32'(stable), 1);
      OutReady = 1'b1;
      wait_done(cyc);
      finish_checks("stall", 8);

      // All-zero rows.
      for (int i = 0; i < 8; i++) rows[i] = '0;
      start_scan(8);
      wait_done(cyc);
      finish_checks("zero", 8);

      // Ignored restart, then reset during beat 4.
      rows[0] = 40; rows[1] = 30; rows[2] = 20; rows[3] = 10;
      rows[4] = 50; rows[5] = 60; rows[6] = 70; rows[7] = 80;
      start_scan(8);
      repeat (4) step();
      Start = 1'b1; Count = 4'd2;
      step();
      Start = 1'b0;
      guard = 0;
      while (!(OutValid && OutIndex == 3'd4) && guard < 100) begin step(); guard++; end
      check("midscan_reach_beat4", 32'(OutIndex), 32'd4);
      CLRN = 1'b0; OutReady = 1'b0;
      step();
      check_reset_outputs("midreset");
      check("midreset_beats_left", 32'(sb.size()), 32'd4);
      sb.delete();
      CLRN = 1'b1; OutReady = 1'b1;
      step();
      check("midreset_idle", 32'(Busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
